jpeg_packetizer: RTL and testbench



---
 rtl/pkt_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 47 ++++
 rtl/jpeg_packetizer.sv | 156 +++++++++++++++
 tb/tb_jpeg_packetizer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared types and constants for the MJPEG chunk packetizer: header layout,
// flag positions and the per-chunk descriptor.
package pkt_pkg;

    localparam logic [7:0] MAGIC0   = 8'hA5;
    localparam logic [7:0] MAGIC1   = 8'h5A;
    localparam int         HDR_LEN  = 8;
    localparam int         FLAG_EOI = 0;
    localparam int         FLAG_OVF = 1;

    typedef struct packed {
        logic [7:0]  fid;
        logic [15:0] cidx;
        logic [7:0]  flags;
        logic [15:0] len;
    } desc_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY
    } state_t;

    // Header byte at position idx for the given descriptor (big-endian fields).
    function automatic logic [7:0] hdr_byte(input desc_t d, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = MAGIC0;
            3'd1:    b = MAGIC1;
            3'd2:    b = d.fid;
            3'd3:    b = d.cidx[15:8];
            3'd4:    b = d.cidx[7:0];
            3'd5:    b = d.flags;
            3'd6:    b = d.len[15:8];
            default: b = d.len[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is always visible
// on rdata while the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jpeg_packetizer.sv
// Cuts the non-stallable MJPEG byte stream into bounded chunks and emits each
// as an 8-byte header followed by its payload on a valid/ready byte port.
module jpeg_packetizer
    import pkt_pkg::*;
#(
    parameter int CHUNK_BYTES = 1024,
    parameter int DATA_AW     = 11,
    parameter int DESC_AW     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] drop_cnt
);

    localparam logic [15:0] CHUNK_LEN = 16'(CHUNK_BYTES);

    logic        d_full, d_empty, d_pop;
    logic        q_full, q_empty, q_pop;
    logic [7:0]  d_head;
    desc_t       q_in, q_head, desc;

    logic        acc, drop, eoi, close;
    logic [15:0] pay_len, chunk_idx, pay_cnt;
    logic [7:0]  frame_id;
    logic        prev_ff, ovf;
    logic [2:0]  hidx;
    state_t      state, state_nxt;

    // Both FIFOs gate acceptance so a closing byte always has a descriptor slot.
    assign acc   = in_valid & ~d_full & ~q_full;
    assign drop  = in_valid & ~acc;
    assign eoi   = acc & prev_ff & (in_data == 8'hD9);
    assign close = acc & ((pay_len + 16'd1 == CHUNK_LEN) | eoi);

    always_comb begin
        q_in                 = '0;
        q_in.fid             = frame_id;
        q_in.cidx            = chunk_idx;
        q_in.flags[FLAG_EOI] = eoi;
        q_in.flags[FLAG_OVF] = ovf | drop;
        q_in.len             = pay_len + 16'd1;
    end

    sync_fifo #(.WIDTH(8), .AW(DATA_AW)) u_data (
        .clk   (clk),
        .rst   (rst),
        .push  (acc),
        .wdata (in_data),
        .pop   (d_pop),
        .rdata (d_head),
        .full  (d_full),
        .empty (d_empty)
    );

    sync_fifo #(.WIDTH($bits(desc_t)), .AW(DESC_AW)) u_desc (
        .clk   (clk),
        .rst   (rst),
        .push  (close),
        .wdata (q_in),
        .pop   (q_pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pay_len   <= '0;
            chunk_idx <= '0;
            frame_id  <= '0;
            prev_ff   <= 1'b0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (drop) begin
                prev_ff <= 1'b0;
                ovf     <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            if (acc) begin
                prev_ff <= (in_data == 8'hFF);
                if (close) begin
                    pay_len <= '0;
                    ovf     <= 1'b0;
                    if (eoi) begin
                        chunk_idx <= '0;
                        frame_id  <= frame_id + 8'd1;
                    end else begin
                        chunk_idx <= chunk_idx + 16'd1;
                    end
                end else begin
                    pay_len <= pay_len + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            desc    <= '0;
            hidx    <= '0;
            pay_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && !q_empty) begin
                desc    <= q_head;
                hidx    <= '0;
                pay_cnt <= '0;
            end
            if (state == HDR && out_ready) hidx    <= hidx + 3'd1;
            if (d_pop)                     pay_cnt <= pay_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        d_pop     = 1'b0;
        q_pop     = 1'b0;
        case (state)
            IDLE: if (!q_empty) state_nxt = HDR;
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_byte(desc, hidx);
                out_first = (hidx == 3'd0);
                if (out_ready && hidx == 3'(HDR_LEN - 1)) state_nxt = PAY;
            end
            PAY: begin
                // A closed chunk's bytes are already queued; the empty check is defensive.
                out_valid = ~d_empty;
                out_data  = d_head;
                out_last  = ~d_empty & (pay_cnt == desc.len - 16'd1);
                if (out_ready && !d_empty) begin
                    d_pop = 1'b1;
                    if (out_last) begin
                        q_pop     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jpeg_packetizer.sv
// Randomized bench for jpeg_packetizer: two instances (1024- and 4-byte
// chunks) are checked byte-by-byte against a chunking model of the stream.
module tb_jpeg_packetizer;

    localparam int CH_A = 1024;
    localparam int CH_B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b0;
    logic        in_valid [2];
    logic [7:0]  in_data  [2];
    logic        ov [2];
    logic        of [2];
    logic        ol [2];
    logic [7:0]  od [2];
    logic [15:0] dc [2];

    int n_cmp = 0;
    int n_bad = 0;
    int rr_mode = 0;

    // reference model state, one slot per instance
    int         m_fid  [2];
    int         m_cidx [2];
    int         m_plen [2];
    int         m_drop [2];
    bit         m_pff  [2];
    bit         m_ovf  [2];
    logic [7:0] m_pend [2][2048];
    logic [9:0] exp_a [$];
    logic [9:0] exp_b [$];

    logic [9:0] mon_e;
    logic [9:0] pv    [2];
    bit         stall [2];

    always #5 clk = ~clk;

    jpeg_packetizer #(.CHUNK_BYTES(CH_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_first(of[0]), .out_last(ol[0]), .drop_cnt(dc[0])
    );

    jpeg_packetizer #(.CHUNK_BYTES(CH_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_first(of[1]), .out_last(ol[1]), .drop_cnt(dc[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int chunk_sz(input int u);
        return (u == 0) ? CH_A : CH_B;
    endfunction

    function automatic void exp_push(input int u, input logic [9:0] e);
        if (u == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? exp_a.size() : exp_b.size();
    endfunction

    function automatic logic [9:0] qpop(input int u);
        return (u == 0) ? exp_a.pop_front() : exp_b.pop_front();
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_fid[u] = 0; m_cidx[u] = 0; m_plen[u] = 0; m_drop[u] = 0;
            m_pff[u] = 0; m_ovf[u] = 0;
        end
        exp_a.delete();
        exp_b.delete();
    endfunction

    // Expected entries are {first, last, data}; a chunk's bytes are queued
    // only once the chunk is closed.
    task automatic model_byte(input int u, input logic [7:0] b, input bit dropped);
        logic [7:0] hdr [8];
        bit eoi;
        int len;
        if (dropped) begin
            m_ovf[u] = 1;
            m_pff[u] = 0;
            if (m_drop[u] < 65535) m_drop[u]++;
            return;
        end
        eoi = m_pff[u] && (b == 8'hD9);
        m_pff[u] = (b == 8'hFF);
        m_pend[u][m_plen[u]] = b;
        m_plen[u]++;
        if (m_plen[u] == chunk_sz(u) || eoi) begin
            len = m_plen[u];
            hdr = '{8'hA5, 8'h5A, 8'(m_fid[u]), 8'(m_cidx[u] >> 8), 8'(m_cidx[u]),
                    {6'd0, m_ovf[u], eoi}, 8'(len >> 8), 8'(len)};
            for (int i = 0; i < 8; i++) exp_push(u, {i == 0, 1'b0, hdr[i]});
            for (int i = 0; i < len; i++) exp_push(u, {1'b0, i == len - 1, m_pend[u][i]});
            m_plen[u] = 0;
            m_ovf[u]  = 0;
            if (eoi) begin
                m_cidx[u] = 0;
                m_fid[u]  = (m_fid[u] + 1) % 256;
            end else begin
                m_cidx[u] = (m_cidx[u] + 1) % 65536;
            end
        end
    endtask

    task automatic send(input int u, input logic [7:0] b, input bit dropped);
        @(posedge clk); #1;
        in_valid[u]     = 1'b1;
        in_data[u]      = b;
        in_valid[1 - u] = 1'b0;
        model_byte(u, b, dropped);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid[0] = 1'b0;
            in_valid[1] = 1'b0;
        end
    endtask

    task automatic rand_frame(input int u, input int n, input bit gaps);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (u == 1) ? 8'($urandom_range(0, 254)) : 8'($urandom_range(0, 255));
            send(u, b, 1'b0);
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
        end
        send(u, 8'hFF, 1'b0);
        send(u, 8'hD9, 1'b0);
        idle(1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        chk("drain_left", 32'(exp_a.size() + exp_b.size()), 0);
        idle(3);
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (rr_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: in-order byte check plus hold-while-stalled check.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                stall[u] = 0;
            end else begin
                if (stall[u])
                    chk("hold", {ov[u], of[u], ol[u], od[u]}, {1'b1, pv[u]});
                if (ov[u] && out_ready) begin
                    if (qsize(u) == 0) begin
                        chk("spurious_byte", 32'(qsize(u)), 1);
                    end else begin
                        mon_e = qpop(u);
                        chk(u == 0 ? "out_a" : "out_b", {of[u], ol[u], od[u]}, mon_e);
                    end
                end
                stall[u] = ov[u] && !out_ready;
                pv[u]    = {of[u], ol[u], od[u]};
            end
        end
    end

    initial begin
        in_valid[0] = 0; in_valid[1] = 0;
        in_data[0]  = 0; in_data[1]  = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_valid", ov[u], 0);
            chk("rst_marks", {of[u], ol[u]}, 0);
            chk("rst_data", od[u], 0);
            chk("rst_drop", dc[u], 0);
        end
        @(posedge clk); #1 rst = 0;

        // short frame, ready high: header 0 two cycles after D9, 8+6 byte burst
        rr_mode = 1;
        idle(2);
        send(0, 8'hFF, 0); send(0, 8'hD8, 0); send(0, 8'h11, 0);
        send(0, 8'h22, 0); send(0, 8'hFF, 0); send(0, 8'hD9, 0);
        idle(1);
        @(negedge clk);
        chk("short_n1_valid", ov[0], 0);
        @(negedge clk);
        chk("short_hdr0", {ov[0], of[0], od[0]}, {2'b11, 8'hA5});
        repeat (13) @(negedge clk);
        chk("short_last", {ov[0], ol[0], od[0]}, {2'b11, 8'hD9});
        drain();

        // multi-chunk frame on the 4-byte instance, then the next frame
        for (int i = 0; i < 8; i++) send(1, 8'($urandom_range(0, 254)), 0);
        send(1, 8'hFF, 0); send(1, 8'hD9, 0);
        idle(1);
        chk("multi_fid_model", 32'(m_fid[1]), 1);
        rand_frame(1, 3, 0);
        drain();

        // random backpressure on both instances
        rr_mode = 2;
        for (int f = 0; f < 4; f++) begin
            rand_frame(0, $urandom_range(1, 200), 1);
            drain();
        end
        for (int f = 0; f < 6; f++) begin
            rand_frame(1, $urandom_range(1, 30), 1);
            drain();
        end
        chk("drop_none_a", dc[0], 32'(m_drop[0]));
        chk("drop_none_b", dc[1], 32'(m_drop[1]));

        // overflow with ready low; the last accepted byte is FF, the next is
        // dropped, so the later D9 must not close the frame
        rr_mode = 0;
        idle(3);
        for (int i = 0; i < 2047; i++) send(0, 8'($urandom_range(0, 254)), 0);
        send(0, 8'hFF, 0);
        send(0, 8'h11, 1);
        send(0, 8'h22, 1);
        idle(1);
        @(negedge clk);
        chk("ovf_drop_cnt", dc[0], 32'(m_drop[0]));
        chk("ovf_drop_two", dc[0], 2);
        rr_mode = 1;
        idle(30);
        send(0, 8'hD9, 0);
        send(0, 8'h33, 0);
        send(0, 8'hFF, 0);
        send(0, 8'hD9, 0);
        idle(1);
        drain();
        chk("ovf_drop_hold", dc[0], 2);

        // reset while a chunk payload is streaming out
        for (int i = 0; i < 40; i++) send(0, 8'($urandom_range(0, 254)), 0);
        send(0, 8'hFF, 0); send(0, 8'hD9, 0);
        idle(15);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", ov[0], 0);
        chk("rstmid_out", {of[0], ol[0], od[0]}, 0);
        chk("rstmid_drop", dc[0], 0);
        rr_mode = 2;
        rand_frame(0, 10, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
